// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter and the FIFO instance it feeds.
package fifo_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_e;

    localparam int DEFAULT_BITS = 8;

endpackage

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between two byte producers,
// with a post-reset settle window and a saturating full-stall counter.
//
// state | meaning
// INIT  | waiting for the FIFO flags to settle; fifo_full ignored
// IDLE  | sampling requests and fifo_full, may grant
// HOLD  | one-cycle gap after a grant; requests ignored
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int Bits       = DEFAULT_BITS,
    parameter int InitCycles = 2,
    parameter int StallWidth = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [Bits-1:0]       data0,
    output logic                  ack0,
    input  logic                  req1,
    input  logic [Bits-1:0]       data1,
    output logic                  ack1,
    input  logic                  fifo_full,
    output logic                  fifo_wr,
    output logic [Bits-1:0]       fifo_din,
    input  logic                  stall_clr,
    output logic [StallWidth-1:0] stall_cnt,
    output logic                  last_grant,
    output logic                  busy
);

    localparam int              CntW     = $clog2(InitCycles);
    localparam logic [CntW-1:0] InitLast = CntW'(InitCycles - 1);

    arb_state_e            state_q;
    logic [CntW-1:0]       init_cnt_q;
    logic                  prio_q;
    logic                  wr_q;
    logic [Bits-1:0]       din_q;
    logic                  ack0_q;
    logic                  ack1_q;
    logic [StallWidth-1:0] stall_q;
    logic                  last_q;
    logic                  busy_q;

    logic req_any_d;
    logic pick1_d;
    logic stall_sat_d;

    assign req_any_d   = req0 | req1;
    // Requester 1 wins when it is alone, or when both ask and it holds priority.
    assign pick1_d     = req1 & (~req0 | prio_q);
    assign stall_sat_d = &stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            prio_q     <= 1'b0;
            wr_q       <= 1'b0;
            din_q      <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            stall_q    <= '0;
            last_q     <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            wr_q   <= 1'b0;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            if (stall_clr) begin
                stall_q <= '0;
            end
            case (state_q)
                ST_INIT: begin
                    busy_q <= 1'b1;
                    if (init_cnt_q == InitLast) begin
                        init_cnt_q <= '0;
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                    end else begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req_any_d && !fifo_full) begin
                        state_q <= ST_HOLD;
                        busy_q  <= 1'b1;
                        wr_q    <= 1'b1;
                        din_q   <= pick1_d ? data1 : data0;
                        ack0_q  <= ~pick1_d;
                        ack1_q  <= pick1_d;
                        last_q  <= pick1_d;
                        prio_q  <= ~pick1_d;
                    end else if (req_any_d && !stall_clr && !stall_sat_d) begin
                        stall_q <= stall_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= ST_INIT;
                    init_cnt_q <= '0;
                    busy_q     <= 1'b1;
                end
            endcase
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign fifo_wr    = wr_q;
    assign fifo_din   = din_q;
    assign stall_cnt  = stall_q;
    assign last_grant = last_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench: a queue-based FIFO plus a behavioural arbiter model,
// compared against the DUT on every falling edge, with directed scenarios.
module tb_fifo_write_arbiter;

    localparam int Bits       = 8;
    localparam int InitCycles = 2;
    localparam int StallWidth = 4;
    localparam int Depth      = 16;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  req0 = 1'b0;
    logic [Bits-1:0]       data0 = '0;
    logic                  ack0;
    logic                  req1 = 1'b0;
    logic [Bits-1:0]       data1 = '0;
    logic                  ack1;
    logic                  fifo_full = 1'b0;
    logic                  fifo_wr;
    logic [Bits-1:0]       fifo_din;
    logic                  stall_clr = 1'b0;
    logic [StallWidth-1:0] stall_cnt;
    logic                  last_grant;
    logic                  busy;
    logic                  rd = 1'b0;

    int checks = 0;
    int failures = 0;

    fifo_write_arbiter #(
        .Bits(Bits), .InitCycles(InitCycles), .StallWidth(StallWidth)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_din(fifo_din),
        .stall_clr(stall_clr), .stall_cnt(stall_cnt),
        .last_grant(last_grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: expected outputs for the cycle after each edge.
    int              init_left;
    bit              holding;
    bit              prio_m;
    logic            e_wr, e_ack0, e_ack1, e_lg, e_busy;
    logic [Bits-1:0] e_din;
    int              e_stall;
    logic [Bits-1:0] fq[$];
    logic            wr_s;
    logic [Bits-1:0] din_s;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            init_left = InitCycles;
            holding = 0;
            prio_m = 0;
            e_wr = 0; e_ack0 = 0; e_ack1 = 0; e_lg = 0; e_busy = 1;
            e_din = '0;
            e_stall = 0;
            fq.delete();
        end else begin
            bit w;
            e_wr = 0; e_ack0 = 0; e_ack1 = 0;
            if (init_left > 0) begin
                init_left--;
                e_busy = (init_left > 0);
            end else if (holding) begin
                holding = 0;
                e_busy = 0;
            end else if ((req0 || req1) && !fifo_full) begin
                w = (req0 && req1) ? prio_m : req1;
                e_wr = 1;
                e_din = w ? data1 : data0;
                e_ack0 = !w;
                e_ack1 = w;
                e_lg = w;
                prio_m = !w;
                holding = 1;
                e_busy = 1;
            end else if ((req0 || req1) && !stall_clr) begin
                e_stall = (e_stall + 1 > (1 << StallWidth) - 1) ? (1 << StallWidth) - 1 : e_stall + 1;
            end
            if (stall_clr) e_stall = 0;
            if (wr_s) fq.push_back(din_s);
            if (rd && fq.size() > 0) void'(fq.pop_front());
        end
    end

    always @(negedge clk) begin
        chk("fifo_wr", fifo_wr, e_wr);
        chk("ack0", ack0, e_ack0);
        chk("ack1", ack1, e_ack1);
        chk("busy", busy, e_busy);
        chk("stall_cnt", stall_cnt, e_stall);
        chk("last_grant", last_grant, e_lg);
        if (e_wr) chk("fifo_din", fifo_din, e_din);
        wr_s = fifo_wr;
        din_s = fifo_din;
        fifo_full = (fq.size() >= Depth);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit which, output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (which ? ack1 : ack0) begin
                ok = 1;
                return;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int grants, last_t, t;

        // Reset then idle
        #1 reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("init_busy_c1", busy, 1);
        tick(1);
        chk("init_busy_c2", busy, 0);
        chk("init_stall", stall_cnt, 0);
        chk("init_wr", fifo_wr, 0);

        // Single requester
        req0 = 1'b1; data0 = 8'hA5;
        wait_ack(0, ok);
        chk("single_ack_seen", ok, 1);
        chk("single_din", fifo_din, 8'hA5);
        chk("single_wr", fifo_wr, 1);
        chk("single_lg", last_grant, 0);
        req0 = 1'b0;
        tick(1);
        chk("single_wr_drop", fifo_wr, 0);
        chk("single_q_size", fq.size(), 1);
        if (fq.size() > 0) chk("single_q0", fq[0], 8'hA5);
        rd = 1'b1; tick(1); rd = 1'b0;
        chk("single_q_empty", fq.size(), 0);

        // Round-robin: prio favours 1 after the grant to 0
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
        grants = 0; last_t = -1; t = 0;
        for (int i = 0; i < 60 && grants < 8; i++) begin
            tick(1);
            t++;
            if (fifo_wr) begin
                if (last_t >= 0) chk("rr_spacing", t - last_t, 2);
                last_t = t;
                grants++;
                if (grants == 8) begin
                    req0 = 1'b0; req1 = 1'b0;
                end
            end
        end
        chk("rr_grants", grants, 8);
        tick(1);
        chk("rr_q_size", fq.size(), 8);
        for (int i = 0; i < 8 && i < fq.size(); i++)
            chk("rr_order", fq[i], (i % 2 == 0) ? 8'h22 : 8'h11);
        chk("rr_last_grant", last_grant, 0);
        rd = 1'b1; tick(8); rd = 1'b0;
        chk("rr_drained", fq.size(), 0);

        // Fill 16 bytes, then stall requester 1 for 10 cycles
        req0 = 1'b1;
        for (int n = 0; n < Depth; n++) begin
            data0 = 8'h40 + 8'(n);
            wait_ack(0, ok);
            chk("fill_ack", ok, 1);
        end
        req0 = 1'b0;
        tick(1);
        chk("fill_q_size", fq.size(), 16);
        chk("fill_full", fifo_full, 1);
        req1 = 1'b1; data1 = 8'h77;
        tick(10);
        chk("stall_10", stall_cnt, 10);
        chk("stall_q_size", fq.size(), 16);
        rd = 1'b1; tick(1); rd = 1'b0;
        wait_ack(1, ok);
        chk("unstall_ack", ok, 1);
        chk("unstall_din", fifo_din, 8'h77);
        chk("unstall_stall", stall_cnt, 11);
        chk("unstall_lg", last_grant, 1);
        req1 = 1'b0;
        tick(1);
        chk("refull", fifo_full, 1);
        if (fq.size() == 16) chk("refull_tail", fq[15], 8'h77);

        // Saturation and clear with simultaneous increment
        req0 = 1'b1; data0 = 8'h99;
        tick(20);
        chk("stall_sat", stall_cnt, 4'hF);
        stall_clr = 1'b1;
        tick(1);
        chk("stall_clr", stall_cnt, 0);
        stall_clr = 1'b0;
        tick(1);
        chk("stall_resume", stall_cnt, 1);
        req0 = 1'b0;

        // Async reset during the write cycle
        rd = 1'b1; tick(4); rd = 1'b0;
        chk("pre_reset_q", fq.size(), 12);
        req0 = 1'b1; data0 = 8'h5C;
        wait_ack(0, ok);
        chk("mid_ack_seen", ok, 1);
        chk("mid_wr", fifo_wr, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_wr_drop", fifo_wr, 0);
        chk("async_ack_drop", ack0, 0);
        chk("async_busy", busy, 1);
        tick(2);
        reset = 1'b0;
        wait_ack(0, ok);
        chk("reserve_ack", ok, 1);
        chk("reserve_din", fifo_din, 8'h5C);
        req0 = 1'b0;
        tick(1);
        chk("reserve_q_size", fq.size(), 1);
        if (fq.size() > 0) chk("reserve_q0", fq[0], 8'h5C);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
